color_layer_sched: RTL and testbench

Scheduler that time-multiplexes one `neuron` datapath across the `NUM_NEURONS` output neurons of the colour-detection layer. It holds each neuron's weights and bias in a configuration register bank. For each accepted RGB pixel it issues the neurons back-to-back into the shared pipeline and captures each sigmoid output after the fixed pipeline latency. It then reports the arg-max colour class and its score over a valid/ready handshake.

---
 rtl/color_nn_pkg.sv | 19 +
 rtl/nrn_weight_bank.sv | 38 +++
 rtl/color_layer_sched.sv | 177 +++++++++++++++++
 tb/tb_color_layer_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/color_nn_pkg.sv
// Shared types and constants for the colour-detection layer scheduler.
// The FSM state enum, config field codes and default data width live here.
package color_nn_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_RESULT
    } sched_state_t;

    localparam logic [1:0] FLD_W1   = 2'd0;
    localparam logic [1:0] FLD_W2   = 2'd1;
    localparam logic [1:0] FLD_W3   = 2'd2;
    localparam logic [1:0] FLD_BIAS = 2'd3;

endpackage

// File: rtl/nrn_weight_bank.sv
// Per-neuron weight/bias register file: one write port and a combinational
// read port that returns all four fields of one neuron.
module nrn_weight_bank
    import color_nn_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int NUM_NEURONS = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [$clog2(NUM_NEURONS)+1:0]    wr_addr,
    input  logic [2*DATA_WIDTH-1:0]           wr_data,
    input  logic [$clog2(NUM_NEURONS)-1:0]    rd_idx,
    output logic [2*DATA_WIDTH-1:0]           rd_w1,
    output logic [2*DATA_WIDTH-1:0]           rd_w2,
    output logic [2*DATA_WIDTH-1:0]           rd_w3,
    output logic [2*DATA_WIDTH-1:0]           rd_bias
);

    localparam int IDX_W = $clog2(NUM_NEURONS);

    logic [NUM_NEURONS-1:0][3:0][2*DATA_WIDTH-1:0] mem;

    // Addresses naming a neuron beyond NUM_NEURONS-1 are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mem <= '0;
        else if (wr_en && (int'(wr_addr[IDX_W+1:2]) < NUM_NEURONS))
            mem[wr_addr[IDX_W+1:2]][wr_addr[1:0]] <= wr_data;
    end

    assign rd_w1   = mem[rd_idx][FLD_W1];
    assign rd_w2   = mem[rd_idx][FLD_W2];
    assign rd_w3   = mem[rd_idx][FLD_W3];
    assign rd_bias = mem[rd_idx][FLD_BIAS];

endmodule

// File: rtl/color_layer_sched.sv
// Time-multiplexes one shared neuron pipeline across NUM_NEURONS classes per
// pixel, tracks the arg-max sigmoid output and returns it over valid/ready.
module color_layer_sched
    import color_nn_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int NUM_NEURONS    = 4,
    parameter int NEURON_LATENCY = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_R,
    input  logic [DATA_WIDTH-1:0]            in_G,
    input  logic [DATA_WIDTH-1:0]            in_B,
    input  logic                             cfg_we,
    output logic                             cfg_ready,
    input  logic [$clog2(NUM_NEURONS)+1:0]   cfg_addr,
    input  logic [2*DATA_WIDTH-1:0]          cfg_data,
    output logic [DATA_WIDTH-1:0]            nrn_R,
    output logic [DATA_WIDTH-1:0]            nrn_G,
    output logic [DATA_WIDTH-1:0]            nrn_B,
    output logic [2*DATA_WIDTH-1:0]          nrn_w1,
    output logic [2*DATA_WIDTH-1:0]          nrn_w2,
    output logic [2*DATA_WIDTH-1:0]          nrn_w3,
    output logic [2*DATA_WIDTH-1:0]          nrn_bias,
    input  logic [DATA_WIDTH-1:0]            nrn_out,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [$clog2(NUM_NEURONS)-1:0]   res_class,
    output logic [DATA_WIDTH-1:0]            res_score
);

    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam int AW    = IDX_W + 2;
    localparam int WW    = 2 * DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    sched_state_t state, state_nxt;

    logic [IDX_W-1:0]      issue_cnt, cap_cnt;
    logic [DATA_WIDTH-1:0] pix_r, pix_g, pix_b;
    logic [NEURON_LATENCY:1] vld_q;
    logic [NEURON_LATENCY:0] vld_pipe;
    logic                  capture;
    logic                  accept, cfg_take, res_take;
    logic                  pend_vld;
    logic [AW-1:0]         pend_addr;
    logic [WW-1:0]         pend_data;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [WW-1:0]         wr_data;
    logic [WW-1:0]         bk_w1, bk_w2, bk_w3, bk_bias;

    // vld_pipe[i] marks an issue made i cycles ago; bit LATENCY is the capture slot.
    assign vld_pipe = {vld_q, state == ST_ISSUE};
    assign capture  = vld_pipe[NEURON_LATENCY];

    assign accept   = in_valid && in_ready;
    assign cfg_take = cfg_we && cfg_ready;
    assign res_take = res_valid && res_ready;

    // A write taken together with a pixel is parked until the result handshake,
    // so the pixel in flight still sees the bank as it was before that edge.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = cfg_addr;
        wr_data = cfg_data;
        if (cfg_take && !accept) begin
            wr_en = 1'b1;
        end else if (pend_vld && res_take) begin
            wr_en   = 1'b1;
            wr_addr = pend_addr;
            wr_data = pend_data;
        end
    end

    nrn_weight_bank #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_NEURONS (NUM_NEURONS)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_idx  (issue_cnt),
        .rd_w1   (bk_w1),
        .rd_w2   (bk_w2),
        .rd_w3   (bk_w3),
        .rd_bias (bk_bias)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        cfg_ready = 1'b0;
        res_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready  = 1'b1;
                cfg_ready = 1'b1;
                if (in_valid) state_nxt = ST_ISSUE;
            end
            ST_ISSUE:  if (issue_cnt == LAST_IDX) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (capture && cap_cnt == LAST_IDX) state_nxt = ST_RESULT;
            ST_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        nrn_R    = '0;
        nrn_G    = '0;
        nrn_B    = '0;
        nrn_w1   = '0;
        nrn_w2   = '0;
        nrn_w3   = '0;
        nrn_bias = '0;
        if (state == ST_ISSUE) begin
            nrn_R    = pix_r;
            nrn_G    = pix_g;
            nrn_B    = pix_b;
            nrn_w1   = bk_w1;
            nrn_w2   = bk_w2;
            nrn_w3   = bk_w3;
            nrn_bias = bk_bias;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            issue_cnt <= '0;
            cap_cnt   <= '0;
            vld_q     <= '0;
            pix_r     <= '0;
            pix_g     <= '0;
            pix_b     <= '0;
            res_class <= '0;
            res_score <= '0;
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
        end else begin
            state <= state_nxt;
            vld_q <= vld_pipe[NEURON_LATENCY-1:0];
            if (accept) begin
                pix_r <= in_R;
                pix_g <= in_G;
                pix_b <= in_B;
            end
            if (cfg_take && accept) begin
                pend_vld  <= 1'b1;
                pend_addr <= cfg_addr;
                pend_data <= cfg_data;
            end else if (res_take) begin
                pend_vld  <= 1'b0;
            end
            if (state == ST_ISSUE)
                issue_cnt <= (issue_cnt == LAST_IDX) ? '0 : issue_cnt + IDX_W'(1);
            // First capture loads unconditionally; strict > keeps the lower index on ties.
            if (capture) begin
                cap_cnt <= (cap_cnt == LAST_IDX) ? '0 : cap_cnt + IDX_W'(1);
                if (cap_cnt == '0 || nrn_out > res_score) begin
                    res_score <= nrn_out;
                    res_class <= cap_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_color_layer_sched.sv
// Scoreboarded bench for color_layer_sched with a behavioural 3-stage neuron
// whose output is bias[7:0] + R, so every expected class/score is computable.
module tb_color_layer_sched;
    import color_nn_pkg::*;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int L  = 3;
    localparam int IW = $clog2(N);
    localparam int AW = IW + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0, in_ready;
    logic [DW-1:0] in_R = '0, in_G = '0, in_B = '0;
    logic          cfg_we = 1'b0, cfg_ready;
    logic [AW-1:0] cfg_addr = '0;
    logic [2*DW-1:0] cfg_data = '0;
    logic [DW-1:0] nrn_R, nrn_G, nrn_B;
    logic [2*DW-1:0] nrn_w1, nrn_w2, nrn_w3, nrn_bias;
    logic [DW-1:0] nrn_out;
    logic          res_valid, res_ready = 1'b0;
    logic [IW-1:0] res_class;
    logic [DW-1:0] res_score;

    always #5 clk = ~clk;

    color_layer_sched #(.DATA_WIDTH(DW), .NUM_NEURONS(N), .NEURON_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_R(in_R), .in_G(in_G), .in_B(in_B),
        .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .nrn_R(nrn_R), .nrn_G(nrn_G), .nrn_B(nrn_B),
        .nrn_w1(nrn_w1), .nrn_w2(nrn_w2), .nrn_w3(nrn_w3), .nrn_bias(nrn_bias),
        .nrn_out(nrn_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_class(res_class), .res_score(res_score)
    );

    // Behavioural shared neuron: L-cycle pipeline, never reset.
    logic [DW-1:0] npipe [L] = '{default: '0};
    always @(posedge clk) begin
        npipe[0] <= nrn_bias[DW-1:0] + nrn_R;
        for (int i = 1; i < L; i++) npipe[i] <= npipe[i-1];
    end
    assign nrn_out = npipe[L-1];

    typedef struct { int cls; int score; } res_t;
    res_t          sb[$];
    logic [2*DW-1:0] shadow [N][4];
    int            checks = 0;
    int            failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [DW-1:0] r);
        res_t e;
        logic [DW-1:0] s;
        e.cls = 0;
        e.score = 0;
        for (int k = 0; k < N; k++) begin
            s = shadow[k][3][DW-1:0] + r;
            if (k == 0 || int'(s) > e.score) begin
                e.score = int'(s);
                e.cls = k;
            end
        end
        return e;
    endfunction

    // All tasks start and end right after a falling edge.
    task automatic cfg_write(input int k, input int f, input logic [2*DW-1:0] d);
        cfg_addr = AW'(k * 4 + f);
        cfg_data = d;
        cfg_we   = 1'b1;
        chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
        shadow[k][f] = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic run_pixel(input logic [DW-1:0] r, input bit rb,
                             input bit sw, input int sk, input int sf,
                             input logic [2*DW-1:0] sd);
        int cyc;
        in_R = r; in_G = r ^ 8'h5A; in_B = ~r;
        in_valid = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        sb.push_back(model(r));
        if (sw) begin
            cfg_addr = AW'(sk * 4 + sf);
            cfg_data = sd;
            cfg_we   = 1'b1;
            chk("cfg_ready_sim", 32'(cfg_ready), 32'd1);
            shadow[sk][sf] = sd;
        end
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        cyc = 1;
        for (int k = 0; k < N; k++) begin
            if (rb) begin
                chk("rb_w1",   32'(nrn_w1),   32'(shadow[k][0]));
                chk("rb_w2",   32'(nrn_w2),   32'(shadow[k][1]));
                chk("rb_w3",   32'(nrn_w3),   32'(shadow[k][2]));
                chk("rb_bias", 32'(nrn_bias), 32'(shadow[k][3]));
                chk("rb_R",    32'(nrn_R),    32'(r));
                chk("rb_G",    32'(nrn_G),    32'(r ^ 8'h5A));
            end
            @(negedge clk);
            cyc++;
        end
        chk("nrn_zero_drain", 32'(nrn_w1 | nrn_bias | {8'h00, nrn_R}), 32'd0);
        while (!res_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("res_latency", 32'(cyc), 32'(N + L + 1));
    endtask

    task automatic collect(input int hold);
        res_t e;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb[0];
        for (int h = 0; h < hold; h++) begin
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_class", 32'(res_class), 32'(e.cls));
            chk("bp_score", 32'(res_score), 32'(e.score));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_cfg_ready", 32'(cfg_ready), 32'd0);
            if (h == 3) begin
                in_valid = 1'b1; in_R = 8'hFF;
                cfg_we = 1'b1; cfg_addr = '0; cfg_data = 16'hFFFF;
            end else if (h == 4) begin
                in_valid = 1'b0;
                cfg_we = 1'b0;
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        chk("res_valid", 32'(res_valid), 32'd1);
        chk("res_class", 32'(res_class), 32'(e.cls));
        chk("res_score", 32'(res_score), 32'(e.score));
        chk("in_ready_hs", 32'(in_ready), 32'd0);
        void'(sb.pop_front());
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_after", 32'(res_valid), 32'd0);
        chk("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    task automatic set_biases(input int b0, input int b1, input int b2, input int b3);
        cfg_write(0, 3, 16'(b0));
        cfg_write(1, 3, 16'(b1));
        cfg_write(2, 3, 16'(b2));
        cfg_write(3, 3, 16'(b3));
    endtask

    initial begin
        for (int k = 0; k < N; k++)
            for (int f = 0; f < 4; f++) shadow[k][f] = '0;

        // Reset values
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_class", 32'(res_class), 32'd0);
        chk("rst_res_score", 32'(res_score), 32'd0);
        chk("rst_nrn", 32'(nrn_w1 | nrn_w2 | nrn_w3 | nrn_bias), 32'd0);
        chk("rst_nrn_pix", 32'(nrn_R | nrn_G | nrn_B), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // All 16 fields; bias low bytes give 10,200,50,30 with R=0
        for (int k = 0; k < N; k++)
            for (int f = 0; f < 3; f++) cfg_write(k, f, 16'h1000 * 16'(f + 1) + 16'(k * 17 + 3));
        cfg_write(0, 3, 16'hA00A);
        cfg_write(1, 3, 16'hA1C8);
        cfg_write(2, 3, 16'hA232);
        cfg_write(3, 3, 16'hA31E);
        run_pixel(8'd0, 1'b1, 1'b0, 0, 0, '0);
        collect(0);
        chk("basic_class", 32'(res_class), 32'd1);

        run_pixel(8'd40, 1'b0, 1'b0, 0, 0, '0);
        collect(0);
        run_pixel(8'd60, 1'b0, 1'b0, 0, 0, '0);
        collect(0);

        // Back-pressure with ignored pixel/config pulses, then confirm the bank
        run_pixel(8'd20, 1'b0, 1'b0, 0, 0, '0);
        collect(10);
        run_pixel(8'd5, 1'b1, 1'b0, 0, 0, '0);
        collect(0);

        // Ties
        set_biases(90, 90, 90, 90);
        run_pixel(8'd0, 1'b0, 1'b0, 0, 0, '0);
        collect(0);
        set_biases(5, 70, 70, 3);
        run_pixel(8'd0, 1'b0, 1'b0, 0, 0, '0);
        collect(0);

        // Simultaneous accept + write of neuron 2 bias
        set_biases(10, 20, 30, 40);
        run_pixel(8'd0, 1'b0, 1'b1, 2, 3, 16'd250);
        collect(0);
        run_pixel(8'd0, 1'b1, 1'b0, 0, 0, '0);
        collect(0);

        // Reset in ISSUE cycle 2
        in_R = 8'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_res_valid", 32'(res_valid), 32'd0);
        chk("mrst_nrn", 32'(nrn_w1 | nrn_bias), 32'd0);
        rst = 1'b1;
        for (int k = 0; k < N; k++)
            for (int f = 0; f < 4; f++) shadow[k][f] = '0;
        sb.delete();
        @(negedge clk);
        run_pixel(8'd30, 1'b1, 1'b0, 0, 0, '0);
        collect(0);
        set_biases(1, 2, 99, 4);
        run_pixel(8'd30, 1'b0, 1'b0, 0, 0, '0);
        collect(0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
